// File: rtl/aes_pkg.sv
// aes_pkg: shared types, constants and byte-level transforms for the iterative AES core.
// Latency: n/a (package of constants and combinational helper functions).
// Backpressure: n/a.
// Contents: nr_de_nk, estado_fsm_t {OCIOSO, CIFRANDO, PRONTO}, LARG_BLOCO, LARG_PALAVRA,
//           S-box table, substituiBytes / rotacionaLinhas / multiplicaColunas.
package aes_pkg;

  localparam int LARG_BLOCO   = 128;
  localparam int LARG_PALAVRA = 32;

  typedef enum logic [1:0] {OCIOSO, CIFRANDO, PRONTO} estado_fsm_t;

  // S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic int nr_de_nk(input int nk);
    return nk + 6;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TAB[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // State byte i lives at bits [127-8i -: 8]; byte index = row + 4*column.
  function automatic logic [127:0] substituiBytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127 - 8 * i -: 8] = sbox(s[127 - 8 * i -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] rotacionaLinhas(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int col = 0; col < 4; col++)
      for (int lin = 0; lin < 4; lin++)
        r[127 - 8 * (lin + 4 * col) -: 8] = s[127 - 8 * (lin + 4 * ((col + lin) % 4)) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] multiplicaColunas(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int col = 0; col < 4; col++) begin
      a0 = s[127 - 32 * col -: 8];
      a1 = s[119 - 32 * col -: 8];
      a2 = s[111 - 32 * col -: 8];
      a3 = s[103 - 32 * col -: 8];
      r[127 - 32 * col -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119 - 32 * col -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111 - 32 * col -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103 - 32 * col -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

endpackage

// File: rtl/rodada_aes.sv
// rodada_aes: one combinational AES round (SubBytes, ShiftRows, optional MixColumns, AddRoundKey).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows inputs.
// Ports: bloco (state in), chaveRodada (round key), rodada_final (1 skips MixColumns), saida (state out).
module rodada_aes
  import aes_pkg::*;
(
  input  logic [LARG_BLOCO-1:0] bloco,
  input  logic [LARG_BLOCO-1:0] chaveRodada,
  input  logic                  rodada_final,
  output logic [LARG_BLOCO-1:0] saida
);

  logic [LARG_BLOCO-1:0] deslocado;

  assign deslocado = rotacionaLinhas(substituiBytes(bloco));
  assign saida     = (rodada_final ? deslocado : multiplicaColunas(deslocado)) ^ chaveRodada;

endmodule

// File: rtl/cifrador_aes_iterativo.sv
// cifrador_aes_iterativo: iterative AES-128/192/256 encryptor, one round per clock, shared round logic.
// Latency: accept at edge T, saida_valida after edge T+NR (10/12/14 for NK=4/6/8).
// Backpressure: valid/ready both sides; result held in PRONTO until saida_pronta, next block accepted on the same edge.
// Ports: clk, rst (async, active-high); entrada_valida/entrada_pronta/bloco/chaveExpandida in;
//        saida_valida/saida_pronta/saida out; ocupado = block in flight or held.
// Option: define CIFRA_AES_REGISTRA_CHAVE_EN to capture chaveExpandida on acceptance;
//         otherwise the caller holds chaveExpandida stable until saida_valida rises.
module cifrador_aes_iterativo
  import aes_pkg::*;
#(
  parameter  int NK         = 4,
  localparam int NR         = nr_de_nk(NK),
  localparam int LARG_CHAVE = 128 * (NR + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  entrada_valida,
  output logic                  entrada_pronta,
  input  logic [LARG_BLOCO-1:0] bloco,
  input  logic [LARG_CHAVE-1:0] chaveExpandida,
  output logic                  saida_valida,
  input  logic                  saida_pronta,
  output logic [LARG_BLOCO-1:0] saida,
  output logic                  ocupado
);

  localparam logic [3:0] NR_C = 4'(NR);

  estado_fsm_t           estado_fsm;
  logic [LARG_BLOCO-1:0] estado;
  logic [3:0]            contador;
  logic [LARG_BLOCO-1:0] rodada_saida;
  logic [LARG_BLOCO-1:0] chave_rodada;
  logic [LARG_CHAVE-1:0] chave_src;
  logic [LARG_BLOCO-1:0] chaves [0:NR];
  logic                  aceita;

  // In PRONTO the output handshake frees the state register on the same edge,
  // so a new block can be taken without passing through OCIOSO.
  assign entrada_pronta = (estado_fsm == OCIOSO) || ((estado_fsm == PRONTO) && saida_pronta);
  assign aceita         = entrada_valida && entrada_pronta;
  assign saida_valida   = (estado_fsm == PRONTO);
  assign ocupado        = (estado_fsm != OCIOSO);
  assign saida          = estado;

`ifdef CIFRA_AES_REGISTRA_CHAVE_EN
  logic [LARG_CHAVE-1:0] chave_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chave_reg <= '0;
    end else if (aceita) begin
      chave_reg <= chaveExpandida;
    end
  end

  assign chave_src = chave_reg;
`else
  assign chave_src = chaveExpandida;
`endif

  for (genvar r = 0; r <= NR; r++) begin : g_chaves
    assign chaves[r] = chave_src[LARG_CHAVE - 1 - 128 * r -: 128];
  end

  assign chave_rodada = chaves[contador];

  rodada_aes u_rodada (
    .bloco        (estado),
    .chaveRodada  (chave_rodada),
    .rodada_final (contador == NR_C),
    .saida        (rodada_saida)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_fsm <= OCIOSO;
      estado     <= '0;
      contador   <= '0;
    end else if (aceita) begin
      // Round 0 (AddRoundKey) is folded into acceptance; key 0 always comes straight
      // from the input bus because a captured copy would not exist until this edge.
      estado     <= bloco ^ chaveExpandida[LARG_CHAVE - 1 -: 128];
      contador   <= 4'd1;
      estado_fsm <= CIFRANDO;
    end else begin
      case (estado_fsm)
        CIFRANDO: begin
          estado <= rodada_saida;
          if (contador == NR_C) begin
            estado_fsm <= PRONTO;
          end else begin
            contador <= contador + 4'd1;
          end
        end
        PRONTO: begin
          if (saida_pronta) begin
            estado_fsm <= OCIOSO;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cifrador_aes_iterativo.sv
// tb_cifrador_aes_iterativo: directed bench with FIPS-197 / SP800-38A vectors on NK=4, 6 and 8 instances.
// Latency: checks accept-to-valid distance against NR through a scoreboard of accept cycles.
// Backpressure: exercises held output, overlapped accept and reset mid-block.
module tb_cifrador_aes_iterativo;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int saidas4 = 0;
  logic [127:0] exp_q [$];
  int           lat_q [$];

  // NK=4 instance
  logic          v4, p4, sv4, sp4, oc4;
  logic [127:0]  bloco, s4;
  logic [1407:0] chave4;
  // NK=6 / NK=8 instances (sink always ready)
  logic          v6, p6, sv6, oc6, v8, p8, sv8, oc8;
  logic [127:0]  s6, s8;
  logic [1663:0] chave6;
  logic [1919:0] chave8;

  cifrador_aes_iterativo #(.NK(4)) dut4 (
    .clk(clk), .rst(rst), .entrada_valida(v4), .entrada_pronta(p4), .bloco(bloco),
    .chaveExpandida(chave4), .saida_valida(sv4), .saida_pronta(sp4), .saida(s4), .ocupado(oc4));

  cifrador_aes_iterativo #(.NK(6)) dut6 (
    .clk(clk), .rst(rst), .entrada_valida(v6), .entrada_pronta(p6), .bloco(bloco),
    .chaveExpandida(chave6), .saida_valida(sv6), .saida_pronta(1'b1), .saida(s6), .ocupado(oc6));

  cifrador_aes_iterativo #(.NK(8)) dut8 (
    .clk(clk), .rst(rst), .entrada_valida(v8), .entrada_pronta(p8), .bloco(bloco),
    .chaveExpandida(chave8), .saida_valida(sv8), .saida_pronta(1'b1), .saida(s8), .ocupado(oc8));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: obtido %h esperado %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  // FIPS-197 key expansion; key MSB-aligned in 256 bits, result MSB-aligned in 1920 bits.
  function automatic logic [1919:0] expande(input int nk, input logic [255:0] k);
    logic [31:0]   w [0:59];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] r;
    int            nw;
    nw = 4 * (nk + 7);
    rc = 8'h01;
    r  = '0;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32 * i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i - 1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i - nk] ^ t;
    end
    for (int i = 0; i < nw; i++) r[1919 - 32 * i -: 32] = w[i];
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor for the NK=4 instance, sampled on the falling edge.
  logic prev_sv = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (v4 && p4) lat_q.push_back(cyc + 1);
      if (sv4 && !prev_sv) begin
        chk("lat_fila", lat_q.size() != 0, 1'b1);
        if (lat_q.size() != 0) chk("latencia_nk4", cyc - lat_q.pop_front(), 10);
      end
      if (sv4 && sp4) begin
        chk("saida_fila", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) chk("saida_nk4", s4, exp_q.pop_front());
        saidas4++;
      end
    end
    prev_sv = sv4;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulacao nao terminou");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1919:0] tmp;
    logic [1407:0] kc4, kb4;
    logic [127:0]  pts [4];
    logic [127:0]  cts [4];
    int n, c0;

    pts[0] = 128'h00112233445566778899aabbccddeeff; cts[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    pts[1] = 128'h3243f6a8885a308d313198a2e0370734; cts[1] = 128'h3925841d02dc09fbdc118597196a0b32;
    pts[2] = 128'h6bc1bee22e409f96e93d7e117393172a; cts[2] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    pts[3] = 128'hae2d8a571e03ac9c9eb76fac45af8e51; cts[3] = 128'hf5d3d58503b9699de785895a96fdbaaf;

    tmp = expande(4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});   kc4 = tmp[1919 -: 1408];
    tmp = expande(4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});   kb4 = tmp[1919 -: 1408];
    tmp = expande(6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0});
    chave6 = tmp[1919 -: 1664];
    chave8 = expande(8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);

    v4 = 1'b0; sp4 = 1'b1; v6 = 1'b0; v8 = 1'b0; bloco = '0; chave4 = kc4;

    // Reset state
    repeat (3) tick;
    chk("rst_entrada_pronta", p4, 1'b1);
    chk("rst_saida_valida", sv4, 1'b0);
    chk("rst_ocupado", oc4, 1'b0);
    chk("rst_saida", s4, 128'h0);
    rst = 1'b0;
    tick;

    // NK=4, FIPS-197 C.1
    bloco = pts[0]; chave4 = kc4; exp_q.push_back(cts[0]); v4 = 1'b1;
    tick;
    v4 = 1'b0;
    chk("nk4_ocupado", oc4, 1'b1);
    chk("nk4_cifrando_pronta", p4, 1'b0);
    n = 0;
    while (!sv4 && n < 40) begin tick; n++; end
    chk("nk4_timeout", sv4, 1'b1);
    tick;
    chk("nk4_ocioso", oc4, 1'b0);

    // NK=6, FIPS-197 C.2
    bloco = pts[0]; v6 = 1'b1;
    tick;
    v6 = 1'b0; n = 0;
    while (!sv6 && n < 40) begin tick; n++; end
    chk("lat_nk6", n, 12);
    chk("saida_nk6", s6, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);

    // NK=8, FIPS-197 C.3
    bloco = pts[0]; v8 = 1'b1;
    tick;
    v8 = 1'b0; n = 0;
    while (!sv8 && n < 40) begin tick; n++; end
    chk("lat_nk8", n, 14);
    chk("saida_nk8", s8, 128'h8ea2b7ca516745bfeafc49904b496089);
    tick;

    // Backpressure: sink stalls for 5 cycles
    bloco = pts[1]; chave4 = kb4; exp_q.push_back(cts[1]); sp4 = 1'b0; v4 = 1'b1;
    tick;
    v4 = 1'b0; n = 0;
    while (!sv4 && n < 40) begin tick; n++; end
    chk("bp_timeout", sv4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_saida_estavel", s4, cts[1]);
      chk("bp_entrada_pronta", p4, 1'b0);
      chk("bp_valida", sv4, 1'b1);
      tick;
    end
    c0 = saidas4;
    sp4 = 1'b1;
    #1;
    chk("bp_pronta_libera", p4, 1'b1);
    tick;
    chk("bp_uma_transf", saidas4, c0 + 1);
    chk("bp_ocioso", oc4, 1'b0);
    chk("bp_valida_cai", sv4, 1'b0);

    // Back-to-back: source and sink always ready, 4 blocks
    c0 = saidas4; sp4 = 1'b1; v4 = 1'b1;
    for (int b = 0; b < 4; b++) begin
      bloco  = pts[b];
      chave4 = (b == 0) ? kc4 : kb4;
      exp_q.push_back(cts[b]);
      n = 0;
      while (!p4 && n < 40) begin tick; n++; end
      chk("b2b_aceite", p4, 1'b1);
      tick;
      n = 0;
      while (!sv4 && n < 40) begin tick; n++; end
      chk("b2b_timeout", sv4, 1'b1);
    end
    v4 = 1'b0;
    tick;
    chk("b2b_quatro_saidas", saidas4, c0 + 4);
    chk("b2b_fila_vazia", exp_q.size(), 0);

    // Reset while contador = 5
    bloco = pts[2]; chave4 = kb4; v4 = 1'b1;
    tick;
    v4 = 1'b0;
    repeat (4) tick;
    #2 rst = 1'b1;
    #1;
    chk("rstm_valida", sv4, 1'b0);
    chk("rstm_entrada_pronta", p4, 1'b1);
    chk("rstm_ocupado", oc4, 1'b0);
    chk("rstm_saida", s4, 128'h0);
    exp_q.delete();
    lat_q.delete();
    tick;
    rst = 1'b0;
    tick;
    c0 = saidas4;
    bloco = pts[3]; exp_q.push_back(cts[3]); v4 = 1'b1;
    tick;
    v4 = 1'b0; n = 0;
    while (!sv4 && n < 40) begin tick; n++; end
    chk("rstm_timeout", sv4, 1'b1);
    tick;
    chk("rstm_saida_nova", saidas4, c0 + 1);
    chk("fila_exp_vazia", exp_q.size(), 0);
    chk("fila_lat_vazia", lat_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
